// File: rtl/ssd_scan_controller.sv
// Time-multiplexed scan controller for an 8-digit common-anode seven-segment display.
// Inputs are snapshotted once per frame; each digit slot starts with a dark gap, then a PWM-dimmed ON phase.
module ssd_scan_controller #(
    parameter int TICK_DIV     = 262144,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp_in,
    input  logic        lz_blank,
    input  logic [3:0]  brightness,
    output logic [7:0]  anode,
    output logic [7:0]  cathode,
    output logic        frame_start
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_next_s;
    logic        wrap_s;
    logic [2:0]  idx_r;
    logic [3:0]  pwm_r;
    logic [31:0] sh_value_r;
    logic [7:0]  sh_en_r;
    logic [7:0]  sh_dp_r;
    logic        sh_lz_r;
    logic [3:0]  sh_bright_r;
    logic [3:0]  nib_s;
    logic        lit_s;
    logic [7:0]  anode_next_s;
    logic [7:0]  cathode_next_s;

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0:    hex_seg = 7'b0000001;
            4'h1:    hex_seg = 7'b1001111;
            4'h2:    hex_seg = 7'b0010010;
            4'h3:    hex_seg = 7'b0000110;
            4'h4:    hex_seg = 7'b1001100;
            4'h5:    hex_seg = 7'b0100100;
            4'h6:    hex_seg = 7'b0100000;
            4'h7:    hex_seg = 7'b0001111;
            4'h8:    hex_seg = 7'b0000000;
            4'h9:    hex_seg = 7'b0000100;
            4'hA:    hex_seg = 7'b0001000;
            4'hB:    hex_seg = 7'b1100000;
            4'hC:    hex_seg = 7'b0110001;
            4'hD:    hex_seg = 7'b1000010;
            4'hE:    hex_seg = 7'b0110000;
            4'hF:    hex_seg = 7'b0111000;
            default: hex_seg = 7'b1111111;
        endcase
    endfunction

    // A digit is a leading zero when its nibble and every nibble above it are zero.
    function automatic logic lz_blanked(input logic lz, input logic [31:0] v, input logic [2:0] i);
        logic [31:0] upper;
        upper = v >> {i, 2'b00};
        lz_blanked = lz && (i != 3'd0) && (upper == 32'd0);
    endfunction

    assign wrap_s       = (presc_r == PW'(TICK_DIV - 1));
    assign presc_next_s = wrap_s ? {PW{1'b0}} : presc_r + {{(PW-1){1'b0}}, 1'b1};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= BLANK;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state follows the prescaler value of the coming cycle; a wrap always lands in BLANK.
    always_comb begin
        state_next_s = BLANK;
        if (presc_next_s >= PW'(BLANK_CYCLES)) begin
            state_next_s = ON;
        end else begin
            state_next_s = BLANK;
        end
    end

    // Prescaler, digit index, PWM counter and the per-frame input snapshot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_r     <= {PW{1'b0}};
            idx_r       <= 3'd0;
            pwm_r       <= 4'd0;
            sh_value_r  <= 32'd0;
            sh_en_r     <= 8'd0;
            sh_dp_r     <= 8'd0;
            sh_lz_r     <= 1'b0;
            sh_bright_r <= 4'd0;
        end else begin
            presc_r <= presc_next_s;
            if (wrap_s) begin
                idx_r <= idx_r + 3'd1;
            end
            pwm_r <= (state_r == ON) ? pwm_r + 4'd1 : 4'd0;
            if ((presc_r == {PW{1'b0}}) && (idx_r == 3'd0)) begin
                sh_value_r  <= value;
                sh_en_r     <= digit_en;
                sh_dp_r     <= dp_in;
                sh_lz_r     <= lz_blank;
                sh_bright_r <= brightness;
            end
        end
    end

    // Output decode from the current counter state and shadow settings.
    always_comb begin
        anode_next_s   = 8'hFF;
        cathode_next_s = 8'hFF;
        nib_s = sh_value_r[{idx_r, 2'b00} +: 4];
        lit_s = (state_r == ON) && sh_en_r[idx_r] && (pwm_r <= sh_bright_r)
                && !lz_blanked(sh_lz_r, sh_value_r, idx_r);
        if (lit_s) begin
            anode_next_s   = ~(8'd1 << idx_r);
            cathode_next_s = {hex_seg(nib_s), ~sh_dp_r[idx_r]};
        end else begin
            anode_next_s   = 8'hFF;
            cathode_next_s = 8'hFF;
        end
    end

    // Registered pin drivers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            anode       <= 8'hFF;
            cathode     <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            anode       <= anode_next_s;
            cathode     <= cathode_next_s;
            frame_start <= (presc_r == {PW{1'b0}}) && (idx_r == 3'd0);
        end
    end

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Bench for ssd_scan_controller with TICK_DIV=16, BLANK_CYCLES=4: directed scenarios plus random settings,
// every output cycle compared against a frame/slot arithmetic model.
module tb_ssd_scan_controller;

    localparam int TD = 16;
    localparam int BC = 4;
    localparam int FRAME = TD * 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] value;
    logic [7:0]  digit_en;
    logic [7:0]  dp_in;
    logic        lz_blank;
    logic [3:0]  brightness;
    logic [7:0]  anode;
    logic [7:0]  cathode;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    // model: position within the frame of the next counter state, plus the snapshot
    int          c = 0;
    logic [31:0] m_val = 32'd0;
    logic [7:0]  m_en = 8'd0;
    logic [7:0]  m_dp = 8'd0;
    logic        m_lz = 1'b0;
    logic [3:0]  m_br = 4'd0;
    logic [7:0]  exp_an;
    logic [7:0]  exp_ca;
    logic        exp_fs;

    logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    always #5 clk = ~clk;

    ssd_scan_controller #(.TICK_DIV(TD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst(rst), .value(value), .digit_en(digit_en), .dp_in(dp_in),
        .lz_blank(lz_blank), .brightness(brightness), .anode(anode), .cathode(cathode),
        .frame_start(frame_start)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s c=%0d observed=%h expected=%h", tag, c, obs, expv);
        end
    endtask

    // One clock: predict from current inputs, clock, then compare on the falling edge.
    task automatic tick();
        int p;
        int i;
        logic vis;
        logic [3:0] nib;
        if (!rst) begin
            exp_an = 8'hFF; exp_ca = 8'hFF; exp_fs = 1'b0;
            c = 0;
            m_val = 32'd0; m_en = 8'd0; m_dp = 8'd0; m_lz = 1'b0; m_br = 4'd0;
        end else begin
            if (c == 0) begin
                m_val = value; m_en = digit_en; m_dp = dp_in; m_lz = lz_blank; m_br = brightness;
            end
            p = c % TD;
            i = c / TD;
            nib = 4'((m_val >> (4 * i)) & 32'hF);
            vis = (p >= BC) && m_en[i] && (((p - BC) % 16) <= int'(m_br))
                  && !(m_lz && (i > 0) && ((m_val >> (4 * i)) == 32'd0));
            exp_fs = (c == 0);
            exp_an = vis ? ~(8'd1 << i) : 8'hFF;
            exp_ca = vis ? {seg_tab[nib], ~m_dp[i]} : 8'hFF;
            c = (c + 1) % FRAME;
        end
        @(posedge clk);
        @(negedge clk);
        chk("anode", anode, exp_an);
        chk("cathode", cathode, exp_ca);
        chk("frame_start", {7'd0, frame_start}, {7'd0, exp_fs});
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst = 1'b0; value = 32'd0; digit_en = 8'd0; dp_in = 8'd0; lz_blank = 1'b0; brightness = 4'd0;
        @(negedge clk);
        run(5);

        // basic display at full brightness
        value = 32'h0123ABCD; digit_en = 8'hFF; dp_in = 8'h00; brightness = 4'd15;
        rst = 1'b1;
        run(FRAME);

        // mid-frame change held off until the next snapshot
        run(40);
        value = 32'hFFFFFFFF;
        run(FRAME - 40 + FRAME);

        // leading-zero blanking with a decimal point
        value = 32'h00000040; lz_blank = 1'b1; dp_in = 8'h02;
        run(FRAME * 2);

        // PWM dimming
        value = 32'd0; lz_blank = 1'b0; dp_in = 8'h00; brightness = 4'd3;
        run(FRAME * 2);
        brightness = 4'd0;
        run(FRAME * 2);

        // all digits disabled, then reset in the middle of a slot
        digit_en = 8'h00; brightness = 4'd15; value = 32'h89ABCDEF;
        run(FRAME * 2);
        digit_en = 8'hFF;
        run(FRAME + 21);
        rst = 1'b0;
        run(2);
        rst = 1'b1;
        run(FRAME + 2);

        // random settings changed at random points in the frame
        for (int f = 0; f < 12; f++) begin
            value      = $urandom >> (4 * $urandom_range(0, 8));
            digit_en   = 8'($urandom);
            dp_in      = 8'($urandom);
            lz_blank   = 1'($urandom);
            brightness = 4'($urandom);
            run($urandom_range(1, 2 * FRAME));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
